// File: rtl/reg_write_arbiter_if.sv
// Writer-side bundle for the shared-register arbiter: requests and data in,
// grant/ack handshake and the shared register view out.
interface reg_write_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8
);
   localparam int OW = $clog2(N_REQ);

   logic [N_REQ-1:0]        i_req;
   logic [N_REQ*DATA_W-1:0] i_data;
   logic [N_REQ-1:0]        o_grant;
   logic [N_REQ-1:0]        o_ack;
   logic [DATA_W-1:0]       o_q;
   logic [OW-1:0]           o_owner;
   logic                    o_valid;

   // writers side
   modport master (
      output i_req, i_data,
      input  o_grant, o_ack, o_q, o_owner, o_valid
   );

   // arbiter side
   modport slave (
      input  i_req, i_data,
      output o_grant, o_ack, o_q, o_owner, o_valid
   );
endinterface

// File: rtl/reg_write_arbiter.sv
// One DATA_W-bit register shared by N_REQ writers. A round-robin pick in IDLE
// grants one writer; the following edge (WRITE) loads its data, acks it for
// one cycle and advances the priority pointer past the winner.
module reg_write_arbiter #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8
) (
   input logic                 i_clk,
   input logic                 i_rst,
   reg_write_arbiter_if.slave  bus
);
   localparam int OW = $clog2(N_REQ);

   typedef enum logic {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [OW-1:0]     ptr_q, ptr_d;
   logic [OW-1:0]     win_q, win_d;
   logic [OW-1:0]     owner_q, owner_d;
   logic [N_REQ-1:0]  grant_q, grant_d;
   logic [N_REQ-1:0]  ack_q, ack_d;
   logic [DATA_W-1:0] q_q, q_d;
   logic              valid_q, valid_d;

   logic [N_REQ-1:0]  elig;
   logic              found;
   logic [OW-1:0]     pick;
   logic [OW-1:0]     idx;

   // Round-robin scan starting at ptr; a writer being acked this cycle is
   // masked so it can drop its request without a second grant.
   always_comb begin
      elig  = bus.i_req & ~ack_q;
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = OW'((int'(ptr_q) + k) % N_REQ);
         if (!found && elig[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   // State register plus all datapath registers; reset drops any write in flight.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         owner_q <= '0;
         grant_q <= '0;
         ack_q   <= '0;
         q_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         owner_q <= owner_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
         q_q     <= q_d;
         valid_q <= valid_d;
      end
   end

   // Next state: a grant always leads to exactly one WRITE cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (found) state_d = S_WRITE;
         S_WRITE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs/datapath: grant in IDLE, load + ack + pointer advance in WRITE.
   always_comb begin
      ptr_d   = ptr_q;
      win_d   = win_q;
      owner_d = owner_q;
      grant_d = grant_q;
      ack_d   = ack_q;
      q_d     = q_q;
      valid_d = valid_q;
      case (state_q)
         S_IDLE: begin
            ack_d   = '0;
            grant_d = '0;
            if (found) begin
               grant_d[pick] = 1'b1;
               win_d         = pick;
            end
         end
         S_WRITE: begin
            q_d     = bus.i_data[int'(win_q)*DATA_W +: DATA_W];
            owner_d = win_q;
            valid_d = 1'b1;
            ack_d   = grant_q;
            grant_d = '0;
            ptr_d   = (win_q == OW'(N_REQ-1)) ? '0 : win_q + 1'b1;
         end
         default: begin
            grant_d = '0;
            ack_d   = '0;
         end
      endcase
   end

   assign bus.o_grant = grant_q;
   assign bus.o_ack   = ack_q;
   assign bus.o_q     = q_q;
   assign bus.o_owner = owner_q;
   assign bus.o_valid = valid_q;
endmodule
